// File: rtl/as_rv32i_decoder.sv
// RV32I decode stage: splits the fetched instruction into register addresses,
// immediate, one-hot ALU/opcode classes and exception flags, registered for execute.
module as_rv32i_decoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rs1_addr_q,
  output logic [4:0]  o_rs2_addr_q,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_pc,
  output logic [13:0] o_alu,
  output logic [10:0] o_opcode,
  output logic [3:0]  o_exception,
  output logic        o_ce,
  output logic        o_stall,
  output logic        o_flush
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALU_W = 14;
  localparam int unsigned OPC_W = 11;
  localparam int unsigned EXC_W = 4;

  localparam int unsigned ALU_ADD = 0,  ALU_SUB = 1,  ALU_SLT = 2,  ALU_SLTU = 3;
  localparam int unsigned ALU_XOR = 4,  ALU_OR  = 5,  ALU_AND = 6,  ALU_SLL  = 7;
  localparam int unsigned ALU_SRL = 8,  ALU_SRA = 9,  ALU_EQ  = 10, ALU_NEQ  = 11;
  localparam int unsigned ALU_GE  = 12, ALU_GEU = 13;

  localparam int unsigned OPC_RTYPE = 0, OPC_ITYPE = 1, OPC_LOAD   = 2, OPC_STORE  = 3;
  localparam int unsigned OPC_BRANCH = 4, OPC_JAL  = 5, OPC_JALR   = 6, OPC_LUI    = 7;
  localparam int unsigned OPC_AUIPC = 8, OPC_SYSTEM = 9, OPC_FENCE = 10;

  localparam int unsigned EXC_ILLEGAL = 0, EXC_ECALL = 1, EXC_EBREAK = 2, EXC_MRET = 3;

  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [OPC_W-1:0] w_cls;
  logic [OPC_W-1:0] w_opc;
  logic [ALU_W-1:0] w_alu;
  logic [EXC_W-1:0] w_exc;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_stall_bit;

  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]  r_imm, r_pc;
  logic [2:0]       r_f3;
  logic [ALU_W-1:0] r_alu;
  logic [OPC_W-1:0] r_opc;
  logic [EXC_W-1:0] r_exc;
  logic             r_ce;

  assign w_f3 = i_inst[14:12];
  assign w_f7 = i_inst[31:25];

  assign o_rs1_addr  = i_inst[19:15];
  assign o_rs2_addr  = i_inst[24:20];
  assign o_stall     = i_stall;
  assign o_flush     = i_flush;
  assign w_stall_bit = i_stall || o_stall;

  // Opcode class, legality, ALU select and exception flags
  always_comb begin
    w_cls = '0;
    case (i_inst[6:2])
      5'b01100: w_cls[OPC_RTYPE]  = 1'b1;
      5'b00100: w_cls[OPC_ITYPE]  = 1'b1;
      5'b00000: w_cls[OPC_LOAD]   = 1'b1;
      5'b01000: w_cls[OPC_STORE]  = 1'b1;
      5'b11000: w_cls[OPC_BRANCH] = 1'b1;
      5'b11011: w_cls[OPC_JAL]    = 1'b1;
      5'b11001: w_cls[OPC_JALR]   = 1'b1;
      5'b01101: w_cls[OPC_LUI]    = 1'b1;
      5'b00101: w_cls[OPC_AUIPC]  = 1'b1;
      5'b11100: w_cls[OPC_SYSTEM] = 1'b1;
      5'b00011: w_cls[OPC_FENCE]  = 1'b1;
      default:  ;
    endcase

    w_ill = (i_inst[1:0] != 2'b11) || (w_cls == '0);
    w_alu = '0;
    w_exc = '0;

    if (w_cls[OPC_RTYPE] || w_cls[OPC_ITYPE]) begin
      case (w_f3)
        3'd0: if (w_cls[OPC_RTYPE] && i_inst[30]) w_alu[ALU_SUB] = 1'b1;
              else                                 w_alu[ALU_ADD] = 1'b1;
        3'd1: w_alu[ALU_SLL]  = 1'b1;
        3'd2: w_alu[ALU_SLT]  = 1'b1;
        3'd3: w_alu[ALU_SLTU] = 1'b1;
        3'd4: w_alu[ALU_XOR]  = 1'b1;
        3'd5: if (i_inst[30]) w_alu[ALU_SRA] = 1'b1;
              else            w_alu[ALU_SRL] = 1'b1;
        3'd6: w_alu[ALU_OR]   = 1'b1;
        default: w_alu[ALU_AND] = 1'b1;
      endcase
      if (w_cls[OPC_RTYPE]) begin
        if (w_f7 != 7'h00 && w_f7 != 7'h20) w_ill = 1'b1;
        if (w_f7 == 7'h20 && w_f3 != 3'd0 && w_f3 != 3'd5) w_ill = 1'b1;
      end else begin
        if (w_f3 == 3'd1 && w_f7 != 7'h00) w_ill = 1'b1;
        if (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20) w_ill = 1'b1;
      end
    end else if (w_cls[OPC_BRANCH]) begin
      case (w_f3)
        3'd0: w_alu[ALU_EQ]   = 1'b1;
        3'd1: w_alu[ALU_NEQ]  = 1'b1;
        3'd4: w_alu[ALU_SLT]  = 1'b1;
        3'd5: w_alu[ALU_GE]   = 1'b1;
        3'd6: w_alu[ALU_SLTU] = 1'b1;
        3'd7: w_alu[ALU_GEU]  = 1'b1;
        default: w_ill = 1'b1;
      endcase
    end else begin
      w_alu[ALU_ADD] = 1'b1;
    end

    if (i_inst == 32'h0000_0073) w_exc[EXC_ECALL]  = 1'b1;
    if (i_inst == 32'h0010_0073) w_exc[EXC_EBREAK] = 1'b1;
    if (i_inst == 32'h3020_0073) w_exc[EXC_MRET]   = 1'b1;

    w_opc = w_cls;
    if (w_ill) begin
      w_opc = '0;
      w_alu = '0;
      w_exc = '0;
      w_exc[EXC_ILLEGAL] = 1'b1;
    end
  end

  // Sign-extended immediate chosen by instruction format
  always_comb begin
    w_imm = '0;
    if (w_cls[OPC_ITYPE] || w_cls[OPC_LOAD] || w_cls[OPC_JALR] ||
        w_cls[OPC_SYSTEM] || w_cls[OPC_FENCE])
      w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
    else if (w_cls[OPC_STORE])
      w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    else if (w_cls[OPC_BRANCH])
      w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    else if (w_cls[OPC_LUI] || w_cls[OPC_AUIPC])
      w_imm = {i_inst[31:12], 12'b0};
    else if (w_cls[OPC_JAL])
      w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  end

  // Decoded fields load on an accepted instruction; everything holds while stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
      r_imm <= '0;
      r_f3  <= '0;
      r_pc  <= '0;
      r_alu <= '0;
      r_opc <= '0;
      r_exc <= '0;
      r_ce  <= 1'b0;
    end else if (!w_stall_bit) begin
      r_ce <= i_flush ? 1'b0 : i_ce;
      if (i_ce) begin
        r_rs1 <= i_inst[19:15];
        r_rs2 <= i_inst[24:20];
        r_rd  <= i_inst[11:7];
        r_imm <= w_imm;
        r_f3  <= w_f3;
        r_pc  <= i_pc;
        r_alu <= w_alu;
        r_opc <= w_opc;
        r_exc <= w_exc;
      end
    end
  end

  assign o_rs1_addr_q = r_rs1;
  assign o_rs2_addr_q = r_rs2;
  assign o_rd_addr    = r_rd;
  assign o_imm        = r_imm;
  assign o_funct3     = r_f3;
  assign o_pc         = r_pc;
  assign o_alu        = r_alu;
  assign o_opcode     = r_opc;
  assign o_exception  = r_exc;
  assign o_ce         = r_ce;

endmodule

// File: tb/tb_as_rv32i_decoder.sv
// Bench for the RV32I decode stage: instruction-level reference model plus directed vectors.
module tb_as_rv32i_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_inst = '0, i_pc = '0;
  logic        i_ce = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr;
  logic [31:0] o_imm, o_pc;
  logic [2:0]  o_funct3;
  logic [13:0] o_alu;
  logic [10:0] o_opcode;
  logic [3:0]  o_exception;
  logic        o_ce, o_stall, o_flush;

  as_rv32i_decoder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(i_inst), .i_pc(i_pc), .i_ce(i_ce),
    .i_stall(i_stall), .i_flush(i_flush),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rs1_addr_q(o_rs1_addr_q), .o_rs2_addr_q(o_rs2_addr_q), .o_rd_addr(o_rd_addr),
    .o_imm(o_imm), .o_funct3(o_funct3), .o_pc(o_pc), .o_alu(o_alu),
    .o_opcode(o_opcode), .o_exception(o_exception), .o_ce(o_ce),
    .o_stall(o_stall), .o_flush(o_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [13:0] alu;
    logic [10:0] opc;
    logic [3:0]  exc;
  } dec_t;

  int n_pass = 0;
  int n_total = 0;

  // ALU bit index by funct3 for register/immediate arithmetic, and for branches (-1 = reserved)
  int f3_alu [8] = '{0, 7, 2, 3, 4, 8, 5, 6};
  int br_alu [8] = '{10, 11, -1, -1, 2, 12, 3, 13};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode of one instruction, from the ISA's field definitions
  function automatic dec_t model(input logic [31:0] x, input logic [31:0] pc);
    dec_t d;
    int cls, a, f3, v;
    logic [6:0] f7;
    bit ill;
    d = '0;
    d.rd = x[11:7]; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.f3 = x[14:12]; d.pc = pc;
    f3 = int'(x[14:12]);
    f7 = x[31:25];
    case (x[6:0])
      7'h33: cls = 0;  7'h13: cls = 1;  7'h03: cls = 2;  7'h23: cls = 3;
      7'h63: cls = 4;  7'h6F: cls = 5;  7'h67: cls = 6;  7'h37: cls = 7;
      7'h17: cls = 8;  7'h73: cls = 9;  7'h0F: cls = 10;
      default: cls = -1;
    endcase
    ill = (cls < 0);
    a = 0;
    if (cls == 0) begin
      if (f7 == 7'h00) a = f3_alu[f3];
      else if (f7 == 7'h20 && f3 == 0) a = 1;
      else if (f7 == 7'h20 && f3 == 5) a = 9;
      else ill = 1;
    end else if (cls == 1) begin
      if (f3 == 1 && f7 != 7'h00) ill = 1;
      else if (f3 == 5 && f7 == 7'h20) a = 9;
      else if (f3 == 5 && f7 != 7'h00) ill = 1;
      else a = f3_alu[f3];
    end else if (cls == 4) begin
      a = br_alu[f3];
      if (a < 0) ill = 1;
    end
    case (cls)
      1, 2, 6, 9, 10: v = $signed(x) >>> 20;
      3: v = (($signed(x) >>> 20) & ~31) | int'(x[11:7]);
      4: v = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
      5: v = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048
             + int'(x[30:21]) * 2;
      7, 8: v = int'(x & 32'hFFFF_F000);
      default: v = 0;
    endcase
    d.imm = 32'(v);
    if (ill) d.exc = 4'b0001;
    else begin
      d.opc = 11'(1 << cls);
      d.alu = 14'(1 << a);
      if (x == 32'h0000_0073) d.exc = 4'b0010;
      if (x == 32'h0010_0073) d.exc = 4'b0100;
      if (x == 32'h3020_0073) d.exc = 4'b1000;
    end
    return d;
  endfunction

  dec_t exp_d = '0;
  logic exp_ce = 1'b0;

  // Expected pipeline register contents
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_d  <= '0;
      exp_ce <= 1'b0;
    end else if (!i_stall) begin
      exp_ce <= i_flush ? 1'b0 : i_ce;
      if (i_ce) exp_d <= model(i_inst, i_pc);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ce", 32'(o_ce), 32'(exp_ce));
      chk("rs1_comb", 32'(o_rs1_addr), 32'(i_inst[19:15]));
      chk("rs2_comb", 32'(o_rs2_addr), 32'(i_inst[24:20]));
      chk("stall_out", 32'(o_stall), 32'(i_stall));
      chk("flush_out", 32'(o_flush), 32'(i_flush));
      if (exp_ce) begin
        chk("rd", 32'(o_rd_addr), 32'(exp_d.rd));
        chk("rs1_q", 32'(o_rs1_addr_q), 32'(exp_d.rs1));
        chk("rs2_q", 32'(o_rs2_addr_q), 32'(exp_d.rs2));
        chk("funct3", 32'(o_funct3), 32'(exp_d.f3));
        chk("pc", o_pc, exp_d.pc);
        chk("alu", 32'(o_alu), 32'(exp_d.alu));
        chk("opcode", 32'(o_opcode), 32'(exp_d.opc));
        chk("exception", 32'(o_exception), 32'(exp_d.exc));
        if (!exp_d.exc[0]) chk("imm", o_imm, exp_d.imm);
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+2), return at the next posedge+2
  task automatic cyc(input logic [31:0] inst, input logic [31:0] pc,
                     input logic ce, input logic stall, input logic flush);
    i_inst = inst; i_pc = pc; i_ce = ce; i_stall = stall; i_flush = flush;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ce"}, 32'(o_ce), 32'h0);
    chk({tag, "_rd"}, 32'(o_rd_addr), 32'h0);
    chk({tag, "_rs1q"}, 32'(o_rs1_addr_q), 32'h0);
    chk({tag, "_imm"}, o_imm, 32'h0);
    chk({tag, "_pc"}, o_pc, 32'h0);
    chk({tag, "_alu"}, 32'(o_alu), 32'h0);
    chk({tag, "_opc"}, 32'(o_opcode), 32'h0);
    chk({tag, "_exc"}, 32'(o_exception), 32'h0);
  endtask

  logic [31:0] vecs [40] = '{
    32'h0000A103, 32'h00112223, 32'hFE112E23, 32'h00209463, 32'h0020C463,
    32'h0020F463, 32'h0020E463, 32'h0020D463, 32'h0020A463, 32'h0020B463,
    32'h008000EF, 32'hFF9FF0EF, 32'h000080E7, 32'h123450B7, 32'hFFFFF097,
    32'h0000000F, 32'h30002573, 32'h02208133, 32'h40209133, 32'h00209133,
    32'h4020D133, 32'h0020D133, 32'h0020A133, 32'h0020B133, 32'h0020C133,
    32'h0020E133, 32'h0020F133, 32'h00208133, 32'h00209093, 32'h02009093,
    32'h4020C093, 32'hFFF0A093, 32'hFFF0B093, 32'h8000E093, 32'h0FF0F093,
    32'h0020D093, 32'h6020D093, 32'h00000053, 32'hFFFFFFFF, 32'h10500073
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #1;
    rst_n = 1'b1;

    // addi x1,x0,5
    cyc(32'h00500093, 32'h100, 1, 0, 0);
    chk("addi_rd", 32'(o_rd_addr), 32'd1);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_pc", o_pc, 32'h100);
    chk("addi_opc", 32'(o_opcode), 32'h2);
    chk("addi_alu", 32'(o_alu), 32'h1);
    chk("addi_exc", 32'(o_exception), 32'h0);
    chk("addi_ce", 32'(o_ce), 32'h1);

    // sub x2,x1,x2 then srai x1,x1,2 then beq x0,x0,-4, back-to-back
    cyc(32'h40208133, 32'h104, 1, 0, 0);
    chk("sub_alu", 32'(o_alu), 32'h2);
    chk("sub_opc", 32'(o_opcode), 32'h1);
    chk("sub_rs1q", 32'(o_rs1_addr_q), 32'd1);
    chk("sub_rs2q", 32'(o_rs2_addr_q), 32'd2);
    chk("sub_rd", 32'(o_rd_addr), 32'd2);
    cyc(32'h4020D093, 32'h108, 1, 0, 0);
    chk("srai_alu", 32'(o_alu), 32'h200);
    chk("srai_imm", o_imm, 32'h402);
    cyc(32'hFE000EE3, 32'h10C, 1, 0, 0);
    chk("beq_imm", o_imm, 32'hFFFF_FFFC);
    chk("beq_alu", 32'(o_alu), 32'h400);
    chk("beq_opc", 32'(o_opcode), 32'h10);

    // Stall for 3 cycles with changing input; last stalled cycle also flushes
    cyc(32'h00500093, 32'h200, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(vecs[k], 32'h210 + 32'(k * 4), 1, 1, (k == 2) ? 1'b1 : 1'b0);
      chk("stall_pc", o_pc, 32'h200);
      chk("stall_rd", 32'(o_rd_addr), 32'd1);
      chk("stall_ce", 32'(o_ce), 32'h1);
      chk("stall_o", 32'(o_stall), 32'h1);
    end
    cyc(32'h00112223, 32'h300, 1, 0, 0);
    chk("release_pc", o_pc, 32'h300);
    chk("release_opc", 32'(o_opcode), 32'h8);
    chk("release_imm", o_imm, 32'h4);

    // Flush without stall
    cyc(32'h00500093, 32'h304, 1, 0, 1);
    chk("flush_o", 32'(o_flush), 32'h1);
    chk("flush_ce", 32'(o_ce), 32'h0);
    cyc(32'h00500093, 32'h308, 0, 0, 0);
    chk("bubble_ce", 32'(o_ce), 32'h0);

    // Exception sequence
    cyc(32'h00000000, 32'h400, 1, 0, 0);
    chk("ill_exc", 32'(o_exception), 32'b0001);
    chk("ill_opc", 32'(o_opcode), 32'h0);
    chk("ill_alu", 32'(o_alu), 32'h0);
    cyc(32'h00000073, 32'h404, 1, 0, 0);
    chk("ecall_exc", 32'(o_exception), 32'b0010);
    chk("ecall_opc", 32'(o_opcode), 32'h200);
    cyc(32'h00100073, 32'h408, 1, 0, 0);
    chk("ebreak_exc", 32'(o_exception), 32'b0100);
    cyc(32'h30200073, 32'h40C, 1, 0, 0);
    chk("mret_exc", 32'(o_exception), 32'b1000);

    // Instruction table, with an occasional bubble
    foreach (vecs[i]) cyc(vecs[i], 32'h1000 + 32'(i * 4), (i % 7 == 6) ? 1'b0 : 1'b1, 0, 0);
    foreach (vecs[i]) cyc(vecs[i], 32'h2000 + 32'(i * 4), 1, 0, 0);

    // Reset asserted mid-stall, between clock edges
    cyc(32'h00500093, 32'h500, 1, 0, 0);
    cyc(32'h40208133, 32'h504, 1, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(32'h00500093, 32'h600, 1, 0, 0);
    chk("restart_ce", 32'(o_ce), 32'h1);
    chk("restart_pc", o_pc, 32'h600);
    chk("restart_imm", o_imm, 32'd5);

    cyc(32'h0, 32'h0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
